randn_chk: RTL and testbench
============================

Name: randn_chk

Overview:
- Receive-side checker for the 8-bit lagged-Fibonacci uniform noise stream, recurrence y[n] = y[n-55] - y[n-24] mod 256, as produced by the team's noise sources.
- Self-synchronises by capturing 55 consecutive samples, then predicts every following sample and compares it with what it receives.
- Counts mismatches and drops/re-acquires lock on burst errors.
- Sits at the far end of a noise-injection path (after transport/FIFO/loopback) for BIST and link checks.

Parameters:
- WIN, 256, check-window length in accepted samples (power of two, 16..65536).
- LOSS_THR, 8, mismatches within one window that force loss of lock (1..WIN).
- CNT_W, 32, width of the error and sample counters.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- clr  in  1  synchronous restart: counters to 0, state to FILL; has priority over in_valid
- in_valid  in  1  in_data valid this cycle
- in_data  in  8  received sample, signed two's complement
- locked  out  1  1 while in CHECK
- err_pulse  out  1  one-cycle strobe: the sample accepted in the previous cycle mismatched
- err_cnt  out  CNT_W  total mismatches since reset/clr, saturating
- smp_cnt  out  CNT_W  total samples compared in CHECK since reset/clr, saturating
- relock_cnt  out  8  number of CHECK->FILL transitions, saturating at 255

Behaviour:
- Reset (resetn=0, async): state FILL, fill counter 0, history zeroed, locked=0, err_pulse=0, err_cnt=0, smp_cnt=0, relock_cnt=0, window counters 0.
- History H[1..55] holds signed bytes; H[1] is the newest.
- Each accepted sample (in_valid=1) shifts H: H[k] <= H[k-1] for k = 2..55.
- in_valid=0: nothing changes except err_pulse, which returns to 0.
- Prediction: P = H[55] - H[24], 8-bit wrap-around (mod 256), no saturation.
- FILL:
  - Each accepted sample: H[1] <= in_data, fill counter +1.
  - No comparison in FILL; err_pulse, err_cnt and smp_cnt are unaffected.
  - When the 55th sample is accepted: go to CHECK; locked=1 from the next cycle; window counters cleared.
- CHECK, per accepted sample:
  - Compare in_data with P.
  - H[1] <= P (the predicted value, not the received value), so a single corrupted sample counts exactly once and does not propagate.
  - smp_cnt +1.
  - On mismatch: err_pulse=1 on the next cycle and err_cnt +1.
  - Window sample counter and window error counter advance.
  - On the sample that wraps the window counter (WIN samples), the window error counter clears. If a mismatch lands on the wrap sample, it counts toward the new window.
- Loss of lock:
  - If the window error count reaches LOSS_THR (including the current sample): next state FILL, locked=0 next cycle, fill counter 0, relock_cnt +1.
  - err_cnt still counts that final mismatch.
  - Samples already in H are discarded; the next accepted sample is fill sample 1.
- Latency: locked, err_pulse and all counters update exactly one clk after the accepting edge. No combinational in->out paths.
- Counters hold at all-ones; they do not wrap.
- clr together with in_valid: the sample is dropped and the checker restarts FILL.
- Asserting resetn mid-CHECK aborts immediately to reset values. Re-lock then needs 55 fresh samples.
- A stream captured from the generator's first post-seed output satisfies the recurrence. A leading non-sequence sample (e.g. a 0 after seeding) causes mismatches until loss of lock and re-fill; this is correct behaviour.

Test Plan:
- Fill and lock: reset, then feed 55 consecutive samples from the software recurrence model (any seed) with in_valid=1 continuously -> locked rises the cycle after the 55th sample.
  - Then feed 1000 further samples -> err_cnt=0, smp_cnt=1000, relock_cnt=0.
- Gapped valid: same stream with in_valid toggled randomly (~50% duty) -> identical final counters; locked timing is counted in accepted samples, not cycles.
- Single error: in CHECK, invert bit 3 of one sample -> exactly one err_pulse one cycle later, err_cnt=1, locked stays 1, and the next 200 clean samples add no errors.
- Burst loss: with LOSS_THR=8, WIN=256, corrupt 8 samples within one window -> locked falls after the 8th, err_cnt=8, relock_cnt=1.
  - Then 55 clean samples -> locked rises again.
- Window boundary: 7 errors, then 249 clean samples (window wraps), then 7 more errors -> no loss of lock, err_cnt=14.
- clr and reset: clr pulsed mid-CHECK with in_valid=1 -> locked=0, counters 0, the sample on the clr cycle is ignored, re-lock after 55 samples.
  - resetn asserted asynchronously mid-cycle -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/randn_chk.sv
// randn_chk: receive-side checker for the 8-bit lagged-Fibonacci noise stream
// y[n] = y[n-55] - y[n-24] mod 256.
//
// Purpose
//   Self-synchronises on 55 received samples (FILL). It then predicts each
//   following sample and compares it with the received one (CHECK). It counts
//   mismatches and drops lock when too many errors land in one window.
//
// Ports
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   clr        synchronous restart (counters 0, back to FILL), beats in_valid
//   in_valid   in_data is valid this cycle
//   in_data    received sample (signed byte)
//   locked     1 while in CHECK
//   err_pulse  1-cycle strobe: previously accepted sample mismatched
//   err_cnt    saturating total mismatch count
//   smp_cnt    saturating count of samples compared in CHECK
//   relock_cnt saturating count of CHECK->FILL transitions
module randn_chk #(
   parameter int WIN      = 256,
   parameter int LOSS_THR = 8,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] smp_cnt,
   output logic [7:0]       relock_cnt
);

   localparam int WW = $clog2(WIN);
   localparam int EW = $clog2(WIN + 1);
   localparam logic [EW-1:0] THR = EW'(LOSS_THR);

   typedef enum logic {
      FILL  = 1'b0,
      CHECK = 1'b1
   } state_t;

   state_t        state;
   logic [7:0]    h [1:55];
   logic [5:0]    fill_cnt;
   logic [WW-1:0] win_cnt;
   logic [EW-1:0] win_err;

   logic [7:0]    pred;
   logic          acc;
   logic          mis;
   logic          wrap;
   logic [EW-1:0] win_err_nx;
   logic          lose;

   // Prediction wraps mod 256; H[55] is y[n-55], H[24] is y[n-24].
   assign pred = h[55] - h[24];
   assign acc  = in_valid && !clr;
   assign mis  = (in_data != pred);

   // WIN is a power of two, so the window wraps when win_cnt is all ones.
   // A mismatch on the wrap sample is charged to the fresh window.
   assign wrap       = &win_cnt;
   assign win_err_nx = (wrap ? '0 : win_err) + EW'(mis);
   assign lose       = mis && (win_err_nx >= THR);

   // History shift register. In CHECK the prediction, not the received
   // value, is stored so a corrupted sample cannot poison later predictions.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 1; k <= 55; k++) begin
            h[k] <= '0;
         end
      end else if (acc) begin
         for (int k = 55; k >= 2; k--) begin
            h[k] <= h[k-1];
         end
         h[1] <= (state == FILL) ? in_data : pred;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= FILL;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         fill_cnt   <= '0;
         win_cnt    <= '0;
         win_err    <= '0;
         err_cnt    <= '0;
         smp_cnt    <= '0;
         relock_cnt <= '0;
      end else if (clr) begin
         state      <= FILL;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         fill_cnt   <= '0;
         win_cnt    <= '0;
         win_err    <= '0;
         err_cnt    <= '0;
         smp_cnt    <= '0;
         relock_cnt <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (in_valid) begin
            case (state)
               FILL: begin
                  if (fill_cnt == 6'd54) begin
                     state    <= CHECK;
                     locked   <= 1'b1;
                     fill_cnt <= '0;
                     win_cnt  <= '0;
                     win_err  <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + 6'd1;
                  end
               end
               CHECK: begin
                  win_cnt <= win_cnt + WW'(1);
                  win_err <= win_err_nx;
                  if (~&smp_cnt) begin
                     smp_cnt <= smp_cnt + CNT_W'(1);
                  end
                  if (mis) begin
                     err_pulse <= 1'b1;
                     if (~&err_cnt) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                     end
                  end
                  if (lose) begin
                     state    <= FILL;
                     locked   <= 1'b0;
                     fill_cnt <= '0;
                     if (~&relock_cnt) begin
                        relock_cnt <= relock_cnt + 8'd1;
                     end
                  end
               end
               default: state <= FILL;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_randn_chk.sv
// tb_randn_chk: randomized self-checking bench for randn_chk.
// Stream from a software recurrence model, checked against a queue model.
module tb_randn_chk;

   localparam int WIN      = 256;
   localparam int LOSS_THR = 8;
   localparam int CNT_W    = 32;

   logic             clk;
   logic             resetn;
   logic             clr;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] smp_cnt;
   logic [7:0]       relock_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   randn_chk #(
      .WIN(WIN),
      .LOSS_THR(LOSS_THR),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .clr(clr),
      .in_valid(in_valid),
      .in_data(in_data),
      .locked(locked),
      .err_pulse(err_pulse),
      .err_cnt(err_cnt),
      .smp_cnt(smp_cnt),
      .relock_cnt(relock_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stream generator ----------------
   logic [7:0] g_hist[$];

   function automatic logic [7:0] gen();
      logic [7:0] v;
      if (g_hist.size() < 55) begin
         v = 8'($urandom);
      end else begin
         v = g_hist[0] - g_hist[31];
         void'(g_hist.pop_front());
      end
      g_hist.push_back(v);
      return v;
   endfunction

   // ---------------- reference model ----------------
   logic [7:0] m_q[$];
   bit         m_lock;
   int         m_fill;
   int         m_idx;
   int         m_wid;
   int         m_werr;
   bit         m_pulse;
   longint     m_err;
   longint     m_smp;
   int         m_relock;

   function automatic void m_reset();
      m_q.delete();
      m_lock   = 0;
      m_fill   = 0;
      m_idx    = 0;
      m_wid    = 0;
      m_werr   = 0;
      m_pulse  = 0;
      m_err    = 0;
      m_smp    = 0;
      m_relock = 0;
   endfunction

   function automatic void model(input bit v, input logic [7:0] d,
                                 input bit c);
      logic [7:0] p;
      int         wid;
      if (c) begin
         m_reset();
      end else if (!v) begin
         m_pulse = 0;
      end else if (!m_lock) begin
         m_pulse = 0;
         m_q.push_back(d);
         if (m_q.size() > 55) void'(m_q.pop_front());
         m_fill++;
         if (m_fill == 55) begin
            m_lock = 1;
            m_fill = 0;
            m_idx  = 0;
            m_wid  = 0;
            m_werr = 0;
         end
      end else begin
         // m_q[0] is y[n-55], m_q[31] is y[n-24]
         p = m_q[0] - m_q[31];
         void'(m_q.pop_front());
         m_q.push_back(p);
         m_smp++;
         // The WIN-th sample after lock opens window 1, and so on.
         wid = (m_idx + 1) / WIN;
         if (wid != m_wid) begin
            m_wid  = wid;
            m_werr = 0;
         end
         m_idx++;
         m_pulse = (d != p);
         if (d != p) begin
            m_err++;
            m_werr++;
            if (m_werr >= LOSS_THR) begin
               m_lock = 0;
               m_fill = 0;
               m_q.delete();
               if (m_relock != 255) m_relock++;
            end
         end
      end
   endfunction

   task automatic step(input bit v, input logic [7:0] d, input bit c);
      in_valid = v;
      in_data  = d;
      clr      = c;
      @(posedge clk);
      model(v, d, c);
      @(negedge clk);
      in_valid = 1'b0;
      clr      = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn   = 1'b0;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      m_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (locked !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_locked: got %0d want 0", locked);
      end
      n_cmp++;
      if (err_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_pulse: got %0d want 0", err_pulse);
      end
      n_cmp++;
      if (err_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset_err: got %0d want 0", err_cnt);
      end
      n_cmp++;
      if (smp_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset_smp: got %0d want 0", smp_cnt);
      end
      n_cmp++;
      if (relock_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset_relock: got %0d want 0", relock_cnt);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill_lock();
      g_hist.delete();
      for (int i = 1; i <= 55; i++) begin
         step(1'b1, gen(), 1'b0);
         n_cmp++;
         if (locked !== m_lock || m_lock != (i == 55)) begin
            n_bad++;
            $display("FAIL fill_locked[%0d]: got %0d want %0d",
                     i, locked, (i == 55));
         end
      end
      for (int i = 0; i < 1000; i++) step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (err_cnt !== 0 || m_err != 0) begin
         n_bad++;
         $display("FAIL fill_err: got %0d want 0", err_cnt);
      end
      n_cmp++;
      if (smp_cnt !== 1000 || m_smp != 1000) begin
         n_bad++;
         $display("FAIL fill_smp: got %0d want 1000", smp_cnt);
      end
      n_cmp++;
      if (relock_cnt !== 0) begin
         n_bad++;
         $display("FAIL fill_relock: got %0d want 0", relock_cnt);
      end
      n_cmp++;
      if (locked !== 1'b1) begin
         n_bad++;
         $display("FAIL fill_still_locked: got %0d want 1", locked);
      end
   endtask

   task automatic test_gapped();
      int acc;
      int cyc;
      bit v;
      bit bad_lock;
      resetn = 1'b0;
      #1;
      resetn = 1'b1;
      m_reset();
      g_hist.delete();
      @(negedge clk);
      acc      = 0;
      cyc      = 0;
      bad_lock = 0;
      while (acc < 1055 && cyc < 10000) begin
         v = 1'($urandom_range(0, 1));
         if (v) begin
            step(1'b1, gen(), 1'b0);
            acc++;
         end else begin
            step(1'b0, 8'($urandom), 1'b0);
         end
         cyc++;
         if (locked !== m_lock || m_lock != (acc >= 55)) begin
            if (!bad_lock) begin
               $display("FAIL gap_locked[acc %0d]: got %0d want %0d",
                        acc, locked, (acc >= 55));
            end
            bad_lock = 1;
         end
      end
      n_cmp++;
      if (bad_lock || acc != 1055) begin
         n_bad++;
         $display("FAIL gap_lock_timing: accepted %0d want 1055", acc);
      end
      n_cmp++;
      if (err_cnt !== 0) begin
         n_bad++;
         $display("FAIL gap_err: got %0d want 0", err_cnt);
      end
      n_cmp++;
      if (smp_cnt !== 1000) begin
         n_bad++;
         $display("FAIL gap_smp: got %0d want 1000", smp_cnt);
      end
      n_cmp++;
      if (relock_cnt !== 0) begin
         n_bad++;
         $display("FAIL gap_relock: got %0d want 0", relock_cnt);
      end
   endtask

   task automatic test_single_error();
      for (int i = 0; i < 10; i++) step(1'b1, gen(), 1'b0);
      step(1'b1, gen() ^ 8'h08, 1'b0);
      n_cmp++;
      if (err_pulse !== 1'b1 || !m_pulse) begin
         n_bad++;
         $display("FAIL single_pulse: got %0d want 1", err_pulse);
      end
      n_cmp++;
      if (err_cnt !== 1) begin
         n_bad++;
         $display("FAIL single_err: got %0d want 1", err_cnt);
      end
      step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (err_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL single_pulse_off: got %0d want 0", err_pulse);
      end
      for (int i = 0; i < 199; i++) step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (err_cnt !== 1 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL single_after: err %0d locked %0d want 1 1",
                  err_cnt, locked);
      end
      n_cmp++;
      if (smp_cnt !== m_smp[CNT_W-1:0] || m_smp != 1211) begin
         n_bad++;
         $display("FAIL single_smp: got %0d want 1211", smp_cnt);
      end
   endtask

   task automatic test_burst();
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 55; i++) step(1'b1, gen(), 1'b0);
      for (int e = 1; e <= 8; e++) begin
         step(1'b1, gen() ^ 8'h08, 1'b0);
         n_cmp++;
         if (locked !== m_lock || m_lock != (e < 8)) begin
            n_bad++;
            $display("FAIL burst_locked[%0d]: got %0d want %0d",
                     e, locked, (e < 8));
         end
         if (e < 8) begin
            step(1'b1, gen(), 1'b0);
            step(1'b1, gen(), 1'b0);
         end
      end
      n_cmp++;
      if (err_cnt !== 8 || relock_cnt !== 1) begin
         n_bad++;
         $display("FAIL burst_cnt: err %0d relock %0d want 8 1",
                  err_cnt, relock_cnt);
      end
      for (int i = 0; i < 54; i++) step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (locked !== 1'b0) begin
         n_bad++;
         $display("FAIL burst_prelock: got %0d want 0", locked);
      end
      step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (locked !== 1'b1 || !m_lock) begin
         n_bad++;
         $display("FAIL burst_relock: got %0d want 1", locked);
      end
   endtask

   task automatic test_window();
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 55; i++) step(1'b1, gen(), 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, gen() ^ 8'h08, 1'b0);
      for (int i = 0; i < 249; i++) step(1'b1, gen(), 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, gen() ^ 8'h08, 1'b0);
      n_cmp++;
      if (locked !== 1'b1 || locked !== m_lock) begin
         n_bad++;
         $display("FAIL win_locked: got %0d want 1", locked);
      end
      n_cmp++;
      if (err_cnt !== 14 || relock_cnt !== 0) begin
         n_bad++;
         $display("FAIL win_cnt: err %0d relock %0d want 14 0",
                  err_cnt, relock_cnt);
      end
      // An 8th error in the second window must drop lock.
      step(1'b1, gen() ^ 8'h08, 1'b0);
      n_cmp++;
      if (locked !== 1'b0 || relock_cnt !== 1 || err_cnt !== 15) begin
         n_bad++;
         $display("FAIL win_8th: locked %0d relock %0d err %0d want 0 1 15",
                  locked, relock_cnt, err_cnt);
      end
   endtask

   task automatic test_clr();
      for (int i = 0; i < 60; i++) step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (locked !== 1'b1 || !m_lock) begin
         n_bad++;
         $display("FAIL clr_prelocked: got %0d want 1", locked);
      end
      step(1'b1, gen(), 1'b1);
      n_cmp++;
      if (locked !== 1'b0 || err_cnt !== 0 || smp_cnt !== 0 ||
          relock_cnt !== 0) begin
         n_bad++;
         $display("FAIL clr_state: locked %0d err %0d smp %0d relock %0d want 0",
                  locked, err_cnt, smp_cnt, relock_cnt);
      end
      for (int i = 0; i < 54; i++) step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (locked !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_prelock: got %0d want 0", locked);
      end
      step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (locked !== 1'b1 || smp_cnt !== m_smp[CNT_W-1:0]) begin
         n_bad++;
         $display("FAIL clr_relock: locked %0d smp %0d want 1 0",
                  locked, smp_cnt);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) step(1'b1, gen(), 1'b0);
      step(1'b1, gen() ^ 8'h08, 1'b0);
      n_cmp++;
      if (err_pulse !== 1'b1 || err_cnt !== 1) begin
         n_bad++;
         $display("FAIL arst_pre: pulse %0d err %0d want 1 1",
                  err_pulse, err_cnt);
      end
      #2;
      resetn = 1'b0;
      #1;
      n_cmp++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== 0 ||
          smp_cnt !== 0 || relock_cnt !== 0) begin
         n_bad++;
         $display("FAIL arst_now: locked %0d pulse %0d err %0d smp %0d want 0",
                  locked, err_pulse, err_cnt, smp_cnt);
      end
      @(negedge clk);
      resetn = 1'b1;
      m_reset();
      for (int i = 0; i < 55; i++) step(1'b1, gen(), 1'b0);
      n_cmp++;
      if (locked !== 1'b1 || err_cnt !== 0) begin
         n_bad++;
         $display("FAIL arst_relock: locked %0d err %0d want 1 0",
                  locked, err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_fill_lock();
      test_gapped();
      test_single_error();
      test_burst();
      test_window();
      test_clr();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
